// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

   localparam int unsigned DEF_MAX_LEN = 8;
   localparam int unsigned DEF_CNT_W   = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Width needed to hold a length value in 0..max_len.
   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore serial pattern detector with registered detect pulse.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_load,
   input  logic [MAX_LEN-1:0]        cfg_pattern,
   input  logic [len_w(MAX_LEN)-1:0] cfg_len,
   input  logic                      cfg_overlap,
   input  logic                      in_valid,
   input  logic                      in_bit,
   output logic                      out,
   output logic [CNT_W-1:0]          match_cnt,
   output logic                      cfg_err,
   output logic                      armed
);

   localparam int unsigned LEN_W = len_w(MAX_LEN);

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic               err_q, err_d;
   logic               out_q, out_d;

   logic [MAX_LEN-1:0] hist_sh;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] mask;
   logic               len_ok;

   // For len == MAX_LEN the shift wraps to zero, so the subtraction yields all ones.
   assign mask     = (MAX_LEN'(1) << len_q) - MAX_LEN'(1);
   assign hist_sh  = {hist_q[MAX_LEN-2:0], in_bit};
   assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
   assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      err_d   = err_q;
      out_d   = 1'b0;
      if (cfg_load) begin
         // A load always takes priority; any bit offered alongside it is dropped.
         if (len_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            err_d   = 1'b0;
            state_d = RUN;
         end else begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
      end else if ((state_q == RUN) && in_valid) begin
         hist_d = hist_sh;
         out_d  = (((hist_sh ^ pat_q) & mask) == '0) && (fill_inc >= len_q);
         fill_d = (out_d && !ovl_q) ? '0 : fill_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

`ifdef SEQ_DET_MATCH_CNT_EN
   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (out_d),
      .clr_i (1'b0),
      .cnt_o (match_cnt)
   );
`else
   assign match_cnt = '0;
`endif

   assign out     = out_q;
   assign cfg_err = err_q;
   assign armed   = (state_q == RUN);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog (MAX_LEN=8, CNT_W=2); expectations are hand-derived.
module tb_seq_detector_prog;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_load = 1'b0;
   logic [7:0]       cfg_pattern = '0;
   logic [3:0]       cfg_len = '0;
   logic             cfg_overlap = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             out;
   logic [CNT_W-1:0] match_cnt;
   logic             cfg_err;
   logic             armed;

   int n_checks = 0;
   int n_fail   = 0;
   int hits     = 0;

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .out         (out),
      .match_cnt   (match_cnt),
      .cfg_err     (cfg_err),
      .armed       (armed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected counter value after n detections with a 2-bit saturating counter.
   function automatic logic [31:0] exp_cnt(input int n);
`ifdef SEQ_DET_MATCH_CNT_EN
      return (n > 3) ? 32'd3 : 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      hits = 0;
   endtask

   task automatic send(input logic v, input logic b, input logic exp_out, input string tag);
      cfg_load = 1'b0;
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
      if (exp_out) hits++;
      check({tag, "_out"}, 32'(out), 32'(exp_out));
      check({tag, "_cnt"}, 32'(match_cnt), exp_cnt(hits));
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic v, input logic b);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_valid    = v;
      in_bit      = b;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
      check("load_out", 32'(out), 32'd0);
   endtask

   initial begin
      logic [6:0] s7;
      logic [7:0] s8;
      s7 = 7'b1011011;
      s8 = 8'hA5;

      #1;
      check("rst_out", 32'(out), 32'd0);
      check("rst_cnt", 32'(match_cnt), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      check("rst_armed", 32'(armed), 32'd0);
      @(posedge clk);
      #1;
      do_reset();

      // Unconfigured: nothing detected
      for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b0, "unconf");
      check("unconf_armed", 32'(armed), 32'd0);

      // Overlapping 1011
      load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
      check("ovl_armed", 32'(armed), 32'd1);
      check("ovl_err", 32'(cfg_err), 32'd0);
      for (int i = 6; i >= 0; i--) send(1'b1, s7[i], (i == 3) || (i == 0), "ovl");
      check("ovl_total", 32'(match_cnt), exp_cnt(2));

      // Non-overlapping 1011
      do_reset();
      load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 6; i >= 0; i--) send(1'b1, s7[i], (i == 3), "novl");
      check("novl_total", 32'(match_cnt), exp_cnt(1));

      // Illegal lengths
      load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      check("len0_err", 32'(cfg_err), 32'd1);
      check("len0_armed", 32'(armed), 32'd0);
      load(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
      check("len9_err", 32'(cfg_err), 32'd1);
      check("len9_armed", 32'(armed), 32'd0);
      send(1'b1, 1'b1, 1'b0, "idle_bit");

      // Full-length pattern is legal and matches
      load(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
      check("len8_err", 32'(cfg_err), 32'd0);
      check("len8_armed", 32'(armed), 32'd1);
      for (int i = 7; i >= 0; i--) send(1'b1, s8[i], (i == 0), "len8");

      // Pattern 110 with valid gaps
      load(8'b0000_0110, 4'd3, 1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0, "gap_b1");
      send(1'b0, 1'b0, 1'b0, "gap_g1");
      send(1'b1, 1'b1, 1'b0, "gap_b2");
      send(1'b0, 1'b1, 1'b0, "gap_g2");
      send(1'b0, 1'b0, 1'b0, "gap_g3");
      send(1'b1, 1'b0, 1'b1, "gap_b3");
      send(1'b0, 1'b0, 1'b0, "gap_after");

      // Load collides with a valid bit: bit dropped, history cleared
      send(1'b1, 1'b1, 1'b0, "col_b1");
      send(1'b1, 1'b1, 1'b0, "col_b2");
      load(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0, "col_b3");
      send(1'b1, 1'b1, 1'b0, "col_b4");
      send(1'b1, 1'b1, 1'b0, "col_b5");
      send(1'b1, 1'b0, 1'b1, "col_b6");

      // Saturation with len=1
      do_reset();
      load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 1'b1, "sat");

      // Asynchronous reset mid-stream
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_out", 32'(out), 32'd0);
      check("arst_cnt", 32'(match_cnt), 32'd0);
      check("arst_armed", 32'(armed), 32'd0);
      check("arst_err", 32'(cfg_err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hits = 0;
      send(1'b1, 1'b1, 1'b0, "post_rst");
      check("post_rst_armed", 32'(armed), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
